// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch path: FSM encoding,
// reset/timeout defaults and the instruction-register field layout.
package instr_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_MAX_WAIT = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } fetch_state_t;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] offset;
    } instr_t;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: asynchronous active-low reset to RESET_PC,
// loads d when load is high.
module pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/WAIT/DONE/ERR handshake with memory,
// bounded wait for mem_ready, instruction register and PC update.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        pc_write,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic [31:0] mem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] offset,
    output logic        instr_valid,
    output logic        busy,
    output logic        fetch_error
);

    localparam int              CNT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WAIT);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    instr_t           ir;
    logic             ir_load;
    logic             pc_load;
    logic [31:0]      pc_next;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .load  (pc_load),
        .d     (pc_next),
        .q     (pc)
    );

    assign pc_plus4 = pc + 32'd4;
    assign mem_addr = pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir <= '0;
        end else if (ir_load) begin
            ir <= mem_data_in;
        end
    end

    // All outputs are decoded from state so reset clears them without waiting for a clock.
    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        ir_load       = 1'b0;
        pc_load       = 1'b0;
        pc_next       = pc_plus4;
        mem_read      = 1'b0;
        instr_valid   = 1'b0;
        busy          = 1'b0;
        fetch_error   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pc_write) begin
                    pc_load = 1'b1;
                    pc_next = pc_in;
                end else if (fetch_start) begin
                    state_next = word_aligned(pc) ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                mem_read   = 1'b1;
                busy       = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                mem_read = 1'b1;
                busy     = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_load    = 1'b1;
                    state_next = ST_DONE;
                end else if (wait_cnt == CNT_LIMIT) begin
                    state_next = ST_ERR;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
                state_next  = ST_IDLE;
            end
            ST_ERR: begin
                fetch_error = 1'b1;
                if (pc_write) begin
                    pc_load    = 1'b1;
                    pc_next    = pc_in;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign opcode = ir.opcode;
    assign rs     = ir.rs;
    assign rt     = ir.rt;
    assign offset = ir.offset;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch, timeout, misalignment,
// PC wrap, pc_write priority and asynchronous reset mid-fetch.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        pc_write;
    logic [31:0] pc_in;
    logic [31:0] mem_data_in;
    logic        mem_ready;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] offset;
    logic        instr_valid;
    logic        busy;
    logic        fetch_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_write    (pc_write),
        .pc_in       (pc_in),
        .mem_data_in (mem_data_in),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .offset      (offset),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fetch_error (fetch_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_start = 1'b0; pc_write = 1'b0; mem_ready = 1'b0;
        pc_in = '0; mem_data_in = '0;
        #2 reset = 1'b0;
        #1;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if ({mem_read, instr_valid, busy, fetch_error} !== 4'b0000) begin failures++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_read, instr_valid, busy, fetch_error}); end
        checks++; if ({opcode, rs, rt, offset} !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", {opcode, rs, rt, offset}); end
        checks++; if (pc_plus4 !== 32'h4 || mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got pc_plus4=%h mem_addr=%h exp 4/0", pc_plus4, mem_addr); end
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_basic_fetch();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        checks++; if ({mem_read, busy, instr_valid} !== 3'b110) begin failures++; $display("FAIL fetch_req got=%b exp=110", {mem_read, busy, instr_valid}); end
        tick();
        checks++; if ({mem_read, busy, instr_valid} !== 3'b110) begin failures++; $display("FAIL fetch_wait got=%b exp=110", {mem_read, busy, instr_valid}); end
        mem_ready = 1'b1; mem_data_in = 32'h8C22_0004;
        tick();
        mem_ready = 1'b0; mem_data_in = 32'hDEAD_BEEF;
        checks++; if ({instr_valid, mem_read, busy} !== 3'b101) begin failures++; $display("FAIL fetch_done got=%b exp=101", {instr_valid, mem_read, busy}); end
        checks++; if ({opcode, rs, rt, offset} !== {6'h23, 5'd1, 5'd2, 16'h0004}) begin failures++; $display("FAIL fetch_fields got=%h/%h/%h/%h exp=23/01/02/0004", opcode, rs, rt, offset); end
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL fetch_pc got=%h exp=%h", pc, 32'h4); end
        tick();
        checks++; if ({instr_valid, busy} !== 2'b00) begin failures++; $display("FAIL fetch_idle got=%b exp=00", {instr_valid, busy}); end
        checks++; if ({opcode, rs, rt, offset} !== 32'h8C22_0004) begin failures++; $display("FAIL fetch_ir_hold got=%h exp=8c220004", {opcode, rs, rt, offset}); end
    endtask

    task automatic test_timeout();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        mem_data_in = 32'h1111_2222;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++; if ({busy, mem_read, fetch_error} !== 3'b110) begin failures++; $display("FAIL timeout_wait%0d got=%b exp=110", i, {busy, mem_read, fetch_error}); end
        end
        tick();
        checks++; if ({fetch_error, busy, mem_read} !== 3'b100) begin failures++; $display("FAIL timeout_err got=%b exp=100", {fetch_error, busy, mem_read}); end
        checks++; if (pc !== 32'h4) begin failures++; $display("FAIL timeout_pc got=%h exp=%h", pc, 32'h4); end
        checks++; if ({opcode, rs, rt, offset} !== 32'h8C22_0004) begin failures++; $display("FAIL timeout_ir got=%h exp=8c220004", {opcode, rs, rt, offset}); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++; if ({fetch_error, pc} !== {1'b1, 32'h4}) begin failures++; $display("FAIL timeout_err_hold got err=%b pc=%h exp 1/4", fetch_error, pc); end
        pc_write = 1'b1; pc_in = 32'h0000_0080;
        tick();
        pc_write = 1'b0;
        checks++; if ({fetch_error, busy} !== 2'b00 || pc !== 32'h80) begin failures++; $display("FAIL timeout_recover got err=%b busy=%b pc=%h exp 0/0/80", fetch_error, busy, pc); end
    endtask

    task automatic test_misaligned();
        pc_write = 1'b1; pc_in = 32'h0000_0002;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h2) begin failures++; $display("FAIL misalign_load got=%h exp=%h", pc, 32'h2); end
        fetch_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({fetch_error, mem_read, busy} !== 3'b100) begin failures++; $display("FAIL misalign_err%0d got=%b exp=100", i, {fetch_error, mem_read, busy}); end
        end
        fetch_start = 1'b0;
        pc_write = 1'b1; pc_in = 32'hFFFF_FFFC;
        tick();
        pc_write = 1'b0;
        checks++; if ({fetch_error, pc} !== {1'b0, 32'hFFFF_FFFC}) begin failures++; $display("FAIL misalign_recover got err=%b pc=%h exp 0/fffffffc", fetch_error, pc); end
    endtask

    task automatic test_wrap();
        mem_ready = 1'b1; mem_data_in = 32'h5555_5555;
        tick();
        checks++; if (pc !== 32'hFFFF_FFFC || {opcode, rs, rt, offset} !== 32'h8C22_0004 || busy !== 1'b0) begin failures++; $display("FAIL wrap_ready_idle got pc=%h ir=%h busy=%b exp fffffffc/8c220004/0", pc, {opcode, rs, rt, offset}, busy); end
        mem_ready = 1'b0;
        checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_plus4 got=%h exp=%h", pc_plus4, 32'h0); end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        checks++; if (mem_addr !== 32'hFFFF_FFFC || mem_read !== 1'b1) begin failures++; $display("FAIL wrap_addr got=%h rd=%b exp fffffffc/1", mem_addr, mem_read); end
        tick();
        tick();
        tick();
        mem_ready = 1'b1; mem_data_in = 32'hAC85_FFF0;
        tick();
        mem_ready = 1'b0;
        checks++; if (pc !== 32'h0 || instr_valid !== 1'b1) begin failures++; $display("FAIL wrap_pc got pc=%h valid=%b exp 0/1", pc, instr_valid); end
        checks++; if ({opcode, rs, rt, offset} !== {6'h2B, 5'd4, 5'd5, 16'hFFF0}) begin failures++; $display("FAIL wrap_fields got=%h/%h/%h/%h exp=2b/04/05/fff0", opcode, rs, rt, offset); end
        tick();
    endtask

    task automatic test_pc_write_priority();
        pc_write = 1'b1; fetch_start = 1'b1; pc_in = 32'h0000_0040;
        tick();
        pc_write = 1'b0; fetch_start = 1'b0;
        checks++; if (pc !== 32'h40 || {busy, mem_read} !== 2'b00) begin failures++; $display("FAIL prio_load got pc=%h busy=%b rd=%b exp 40/0/0", pc, busy, mem_read); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_dropped got=%b exp=0", busy); end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        pc_write = 1'b1; pc_in = 32'h0000_0100;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h40 || busy !== 1'b1) begin failures++; $display("FAIL prio_wait_write got pc=%h busy=%b exp 40/1", pc, busy); end
        mem_ready = 1'b1; mem_data_in = 32'h8C22_0004;
        tick();
        mem_ready = 1'b0;
        checks++; if (pc !== 32'h44 || instr_valid !== 1'b1) begin failures++; $display("FAIL prio_done got pc=%h valid=%b exp 44/1", pc, instr_valid); end
        pc_write = 1'b1; pc_in = 32'h0000_0200;
        tick();
        pc_write = 1'b0;
        checks++; if (pc !== 32'h44 || {busy, instr_valid} !== 2'b00) begin failures++; $display("FAIL prio_done_write got pc=%h busy=%b valid=%b exp 44/0/0", pc, busy, instr_valid); end
    endtask

    task automatic test_async_reset();
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        tick();
        checks++; if ({busy, mem_read} !== 2'b11) begin failures++; $display("FAIL areset_pre got=%b exp=11", {busy, mem_read}); end
        #2 reset = 1'b0;
        #1;
        checks++; if ({mem_read, instr_valid, busy, fetch_error} !== 4'b0000) begin failures++; $display("FAIL areset_ctrl got=%b exp=0000", {mem_read, instr_valid, busy, fetch_error}); end
        checks++; if (pc !== 32'h0 || {opcode, rs, rt, offset} !== 32'h0) begin failures++; $display("FAIL areset_state got pc=%h ir=%h exp 0/0", pc, {opcode, rs, rt, offset}); end
        #2 reset = 1'b1;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        checks++; if ({busy, mem_read} !== 2'b11) begin failures++; $display("FAIL areset_first_fetch got=%b exp=11", {busy, mem_read}); end
        tick();
        mem_ready = 1'b1; mem_data_in = 32'h0043_2820;
        tick();
        mem_ready = 1'b0;
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h4 || {opcode, rs, rt, offset} !== 32'h0043_2820) begin failures++; $display("FAIL areset_fetch got valid=%b pc=%h ir=%h exp 1/4/00432820", instr_valid, pc, {opcode, rs, rt, offset}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_timeout();
        test_misaligned();
        test_wrap();
        test_pc_write_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15, SHALL be the number of WAIT cycles tolerated before a fetch timeout.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 fetch_start  in  1  control unit request to fetch the instruction at pc.
REQ-006 pc_write  in  1  load pc from pc_in.
REQ-007 pc_in  in  32  next PC from the PC-source mux.
REQ-008 mem_data_in  in  32  instruction word from memory.
REQ-009 mem_ready  in  1  memory has valid data on mem_data_in.
REQ-010 mem_read  out  1  memory read request.
REQ-011 mem_addr  out  32  fetch address, always equal to pc.
REQ-012 pc  out  32  current PC, including bits [31:28] used for jump-address formation.
REQ-013 pc_plus4  out  32  pc + 4, combinational.
REQ-014 opcode/rs/rt/offset  out  6/5/5/16  IR fields [31:26]/[25:21]/[20:16]/[15:0].
REQ-015 instr_valid  out  1  one-cycle pulse when a new instruction is in IR.
REQ-016 busy  out  1  high in REQ, WAIT and DONE.
REQ-017 fetch_error  out  1  high while in ERR.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT, DONE and ERR.
REQ-019 IDLE with fetch_start=1, pc_write=0 and pc[1:0]=0 SHALL go to REQ; with pc[1:0]!=0 it SHALL go to ERR.
REQ-020 REQ SHALL assert mem_read for 1 cycle, then go to WAIT.
REQ-021 WAIT SHALL hold mem_read=1 and increment the wait counter each cycle without mem_ready.
REQ-022 WAIT with mem_ready=1 SHALL, on the same edge, load IR from mem_data_in, set pc to pc+4, clear the counter and go to DONE.
REQ-023 WAIT SHALL go to ERR when the counter reaches MAX_WAIT without mem_ready; IR and pc SHALL then be unchanged.
REQ-024 DONE SHALL assert instr_valid for exactly 1 cycle, then go to IDLE.
REQ-025 Minimum latency from fetch_start sampled to instr_valid high SHALL be 3 cycles (mem_ready in the first WAIT cycle).
REQ-026 pc_write in IDLE or ERR SHALL load pc_in; pc_write in ERR SHALL also return to IDLE and clear fetch_error.
REQ-027 pc_write in REQ, WAIT or DONE SHALL be ignored.
REQ-028 Simultaneous pc_write and fetch_start in IDLE: pc_write SHALL win and fetch_start SHALL be dropped.
REQ-029 fetch_start SHALL be ignored outside IDLE; mem_ready SHALL be ignored outside WAIT.
REQ-030 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 IR fields SHALL hold their value until the next successful fetch.

Reset
REQ-032 Asserting reset at any time, including mid-fetch, SHALL immediately force: state=IDLE, pc=RESET_PC, IR=0, counter=0, mem_read=0, instr_valid=0, busy=0, fetch_error=0.
REQ-033 The first fetch_start after reset release SHALL be honoured on the first rising edge.

Structure
REQ-034 The FSM state encoding and the RESET_PC/MAX_WAIT defaults SHALL live in the shared CPU package.
REQ-035 The PC register with its async reset and write enable SHALL be a sub-module named pc_reg; the remaining logic SHALL stay flat.

Verification
REQ-036 Reset release, fetch_start, mem_ready in the first WAIT cycle with data 32'h8C22_0004 -> instr_valid 3 cycles later; opcode=6'h23, rs=1, rt=2, offset=16'h0004; pc=4.
REQ-037 mem_ready withheld for 16 WAIT cycles -> fetch_error=1, pc and IR unchanged; then pc_write with pc_in=32'h0000_0080 -> IDLE, pc=32'h80.
REQ-038 pc_write with pc_in=32'h0000_0002, then fetch_start -> ERR, mem_read never asserted.
REQ-039 pc=32'hFFFF_FFFC, fetch completes -> pc=32'h0000_0000.
REQ-040 Reset asserted in WAIT -> all outputs at reset values asynchronously, before the next clk edge.
REQ-041 pc_write and fetch_start together in IDLE with pc_in=32'h40 -> pc=32'h40, busy stays 0; pc_write pulsed during WAIT -> pc unaffected.
